multi_counter: RTL

Parametrised multi-channel successor to the single free-running user-project counter. Provides CHANNELS independent BITS-wide counters, each with a compare register, an up/down mode, auto-reload and a sticky match flag, behind a valid/ready byte-strobed register port. Channel 0 keeps the logic-analyser override and the `count` output so it drops into the existing user-project wrapper. A single `irq` output summarises enabled match flags.

---
 rtl/multi_counter_pkg.sv | 30 +++
 rtl/multi_counter_counter_channel.sv | 95 +++++++++
 rtl/multi_counter.sv | 116 +++++++++++
 3 files changed

// File: rtl/multi_counter_pkg.sv
// Shared definitions for the multi-channel counter: register map, CTRL bit
// positions and the byte-lane merge used by every writable register.
package multi_counter_pkg;

    typedef enum logic [1:0] {
        REG_COUNT   = 2'd0,
        REG_COMPARE = 2'd1,
        REG_CTRL    = 2'd2,
        REG_STATUS  = 2'd3
    } reg_sel_e;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_DOWN   = 1;
    localparam int CTRL_RELOAD = 2;
    localparam int CTRL_IRQ_EN = 3;
    localparam int CTRL_W      = 4;

    // Lanes whose strobe is set take the new byte; callers truncate to their width.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/multi_counter_counter_channel.sv
// One counter channel: count, compare, control and sticky match flag.
// All state advances only when adv (the global clock enable) is high.
module counter_channel
    import multi_counter_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adv,
    input  logic              la_en,
    input  logic [BITS-1:0]   la_value,
    input  logic              wr_count,
    input  logic              wr_compare,
    input  logic              wr_ctrl,
    input  logic              clr_flag,
    input  logic [3:0]        wstrb,
    input  logic [BITS-1:0]   wdata,
    output logic [BITS-1:0]   count,
    output logic [BITS-1:0]   compare,
    output logic [CTRL_W-1:0] ctrl,
    output logic              flag
);

    logic            step;
    logic            at_match;
    logic            match;
    logic [BITS-1:0] stepped;
    logic [BITS-1:0] reload_val;
    logic [BITS-1:0] next_count;

    // Match detection and next-count selection in priority order
    always_comb begin
        step = adv & ctrl[CTRL_EN];
        if (ctrl[CTRL_DOWN]) begin
            at_match   = (count == '0);
            stepped    = count - BITS'(1'b1);
            reload_val = compare;
        end else begin
            at_match   = (count == compare);
            stepped    = count + BITS'(1'b1);
            reload_val = '0;
        end
        // An overriding load of the count replaces the step, so it cannot match.
        match = step & ~la_en & ~wr_count & at_match;

        if (!adv) begin
            next_count = count;
        end else if (la_en) begin
            next_count = la_value;
        end else if (wr_count) begin
            next_count = BITS'(byte_merge(32'(count), 32'(wdata), wstrb));
        end else if (match && ctrl[CTRL_RELOAD]) begin
            next_count = reload_val;
        end else if (step) begin
            next_count = stepped;
        end else begin
            next_count = count;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= next_count;
        end
    end

    // Compare and control registers, byte-lane writable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            compare <= '0;
            ctrl    <= '0;
        end else if (adv) begin
            if (wr_compare) begin
                compare <= BITS'(byte_merge(32'(compare), 32'(wdata), wstrb));
            end
            if (wr_ctrl) begin
                ctrl <= CTRL_W'(byte_merge(32'(ctrl), 32'(wdata), wstrb));
            end
        end
    end

    // Sticky flag; a new match beats a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag <= 1'b0;
        end else if (adv) begin
            flag <= match | (flag & ~clr_flag);
        end
    end

endmodule

// File: rtl/multi_counter.sv
// Multi-channel counter block with a valid/ready register port.
// Channel 0 also drives the legacy count output and accepts the LA override.
module multi_counter
    import multi_counter_pkg::*;
#(
    parameter  int BITS     = 32,
    parameter  int CHANNELS = 4,
    localparam int ADDR_W   = $clog2(CHANNELS) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enb,
    input  logic              valid,
    input  logic [3:0]        wstrb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BITS-1:0]   wdata,
    input  logic [BITS-1:0]   la_write,
    input  logic [BITS-1:0]   la_input,
    output logic              ready,
    output logic [BITS-1:0]   rdata,
    output logic [BITS-1:0]   count,
    output logic              irq
);

    localparam logic [ADDR_W:0] NUM_CH = (ADDR_W + 1)'(CHANNELS);

    logic [ADDR_W-1:0]                 chan_idx;
    reg_sel_e                          reg_sel;
    logic                              in_range;
    logic                              go;
    logic                              is_write;
    logic                              la_any;
    logic [BITS-1:0]                   la_value;
    logic [CHANNELS-1:0]               rd_hit;
    logic [CHANNELS-1:0]               flags;
    logic [CHANNELS-1:0]               irq_ens;
    logic [CHANNELS-1:0][BITS-1:0]     counts;
    logic [CHANNELS-1:0][BITS-1:0]     compares;
    logic [CHANNELS-1:0][CTRL_W-1:0]   ctrls;
    logic [BITS-1:0]                   sel_count;
    logic [BITS-1:0]                   sel_compare;
    logic [CTRL_W-1:0]                 sel_ctrl;
    logic [BITS-1:0]                   rd_value;

    assign chan_idx = addr >> 2'd2;
    assign reg_sel  = reg_sel_e'(addr[1:0]);
    assign in_range = ({1'b0, chan_idx} < NUM_CH);
    assign go       = valid & ~ready & clk_enb;
    assign is_write = |wstrb;
    assign la_any   = |la_write;
    assign la_value = la_input & la_write;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic sel;
        assign rd_hit[i]  = in_range & (chan_idx == ADDR_W'(i));
        assign sel        = go & is_write & rd_hit[i];
        assign irq_ens[i] = ctrls[i][CTRL_IRQ_EN];

        counter_channel #(.BITS(BITS)) u_channel (
            .clk        (clk),
            .reset      (reset),
            .adv        (clk_enb),
            .la_en      ((i == 0) ? la_any : 1'b0),
            .la_value   (la_value),
            .wr_count   (sel & (reg_sel == REG_COUNT)),
            .wr_compare (sel & (reg_sel == REG_COMPARE)),
            .wr_ctrl    (sel & (reg_sel == REG_CTRL)),
            // STATUS is shared by all channels; flag bits all sit in byte lane 0.
            .clr_flag   (go & is_write & in_range & (reg_sel == REG_STATUS) & wstrb[0] & wdata[i]),
            .wstrb      (wstrb),
            .wdata      (wdata),
            .count      (counts[i]),
            .compare    (compares[i]),
            .ctrl       (ctrls[i]),
            .flag       (flags[i])
        );
    end

    // Read mux: pre-write value of the addressed register, zero when out of range
    always_comb begin
        sel_count   = '0;
        sel_compare = '0;
        sel_ctrl    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel_count   = sel_count   | (rd_hit[i] ? counts[i]   : '0);
            sel_compare = sel_compare | (rd_hit[i] ? compares[i] : '0);
            sel_ctrl    = sel_ctrl    | (rd_hit[i] ? ctrls[i]    : '0);
        end
        case (reg_sel)
            REG_COUNT:   rd_value = sel_count;
            REG_COMPARE: rd_value = sel_compare;
            REG_CTRL:    rd_value = BITS'(sel_ctrl);
            REG_STATUS:  rd_value = in_range ? BITS'(flags) : '0;
            default:     rd_value = '0;
        endcase
    end

    // Handshake: one-cycle acknowledge, frozen while clk_enb is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready <= 1'b0;
            rdata <= '0;
        end else if (clk_enb) begin
            if (ready) begin
                ready <= 1'b0;
            end else if (valid) begin
                ready <= 1'b1;
                rdata <= rd_value;
            end
        end
    end

    assign count = counts[0];
    assign irq   = |(flags & irq_ens);

endmodule
